// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants and types for the memory port arbiter
// Contents: arbiter state encoding, default widths, RV32 opcode constants,
//           and the wait-timer width helper.
`ifndef INSR_LEN
`define INSR_LEN 32
`endif

package mem_port_arbiter_pkg;

  localparam int XLEN_DEF    = `INSR_LEN;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_DATA = 2'b01,
    ARB_INSN = 2'b10
  } arb_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // Width of a counter that must be able to hold the value t.
  function automatic int timer_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// rtl/mem_port_arbiter_wait_timer.sv - saturating wait counter with terminal-count flag
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   load  in  restart the count at zero (new access issued)
//   inc   in  count one waiting cycle
//   tc    out count has reached TIMEOUT (held while saturated)
module mem_port_arbiter_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int W       = timer_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and load/store
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   if_req, if_addr                 fetch request and PC
//   if_rdata, if_valid              buffered instruction and its valid flag
//   dm_read, dm_write               MEM-stage load / store
//   dm_addr, dm_wdata               data address and store data
//   dm_rdata, dm_valid              buffered load data and its valid flag
//   mem_req, mem_we, mem_addr,
//   mem_wdata                       registered request to memory
//   mem_rdata, mem_ack              memory response
//   stall_all                       freeze the whole pipeline
//   err_timeout                     sticky: an access waited TIMEOUT cycles
//   stall_cnt                       free-running count of stalled cycles
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            dm_read,
  input  logic            dm_write,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            stall_all,
  output logic            err_timeout,
  output logic [31:0]     stall_cnt
);

  arb_state_e state, state_nxt;
  logic       dm_pend, if_pend;
  logic       dm_done, if_done;
  logic       issue_dm, issue_if;
  logic       ack_seen;
  logic       tmr_tc;

  assign dm_pend   = (dm_read | dm_write) & ~dm_done;
  assign if_pend   = if_req & ~if_done;
  assign stall_all = rst | dm_pend | if_pend;
  assign if_valid  = if_done;
  assign dm_valid  = dm_done;
  // Acks that arrive while idle (e.g. left over from an access cut by reset) are dropped.
  assign ack_seen  = mem_ack & (state != ARB_IDLE);

  always_comb begin
    state_nxt = state;
    issue_dm  = 1'b0;
    issue_if  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (dm_pend) begin
          state_nxt = ARB_DATA;
          issue_dm  = 1'b1;
        end else if (if_pend) begin
          state_nxt = ARB_INSN;
          issue_if  = 1'b1;
        end
      end
      ARB_DATA, ARB_INSN: begin
        if (mem_ack) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      dm_done     <= 1'b0;
      if_done     <= 1'b0;
      dm_rdata    <= '0;
      if_rdata    <= '0;
      err_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      // Pipeline advances: results have been consumed. Buffers are kept.
      if (!stall_all) begin
        dm_done <= 1'b0;
        if_done <= 1'b0;
      end
      if (issue_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_write;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (issue_if) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end
      if (ack_seen) begin
        mem_req <= 1'b0;
        if (state == ARB_DATA) begin
          dm_done <= 1'b1;
          if (!mem_we) dm_rdata <= mem_rdata;
        end else begin
          if_done  <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
      if (stall_all) stall_cnt <= stall_cnt + 32'd1;
      if (tmr_tc)    err_timeout <= 1'b1;
    end
  end

  mem_port_arbiter_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .load (issue_dm | issue_if),
    .inc  ((state != ARB_IDLE) & ~mem_ack),
    .tc   (tmr_tc)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 4;
  localparam int NCYC = 4000;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_valid;
  logic            dm_read;
  logic            dm_write;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_valid;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;
  logic            stall_all;
  logic            err_timeout;
  logic [31:0]     stall_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .XLEN    (XLEN),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .dm_read     (dm_read),
    .dm_write    (dm_write),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_valid    (dm_valid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stall_all   (stall_all),
    .err_timeout (err_timeout),
    .stall_cnt   (stall_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: one outstanding access at most, described as a transaction.
  bit          m_busy, m_is_data, m_we, m_dm_done, m_if_done, m_err;
  int          m_age, m_delay;
  logic [31:0] m_addr, m_wdata, m_dm_buf, m_if_buf, m_stall_cnt;

  // Current pipeline window (held while the pipeline is stalled).
  bit          w_if_req, w_rd, w_wr;
  logic [31:0] w_if_addr, w_dm_addr, w_dm_wdata;

  int          rst_left;
  bit          stale_kick, ack, e_dm_pend, e_if_pend, e_stall;

  task automatic new_window();
    int op;
    w_if_req   = ($urandom_range(0, 9) != 0);
    op         = $urandom_range(0, 3);
    w_rd       = (op == 1);
    w_wr       = (op == 2);
    w_if_addr  = $urandom & 32'hFFFF_FFFC;
    w_dm_addr  = $urandom & 32'hFFFF_FFFC;
    w_dm_wdata = $urandom;
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_data = 0; m_we = 0; m_dm_done = 0; m_if_done = 0; m_err = 0;
    m_age = 0; m_delay = 0;
    m_addr = '0; m_wdata = '0; m_dm_buf = '0; m_if_buf = '0; m_stall_cnt = '0;
  endtask

  task automatic start_access(input bit is_data);
    int r;
    m_busy    = 1;
    m_is_data = is_data;
    m_age     = 1;
    r         = $urandom_range(0, 9);
    m_delay   = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 3) : $urandom_range(5, 8);
    if (is_data) begin
      m_addr  = w_dm_addr;
      m_we    = w_wr;
      m_wdata = w_dm_wdata;
    end else begin
      m_addr = w_if_addr;
      m_we   = 0;
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; dm_read = 0; dm_write = 0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 0;
    model_reset();
    new_window();
    stale_kick = 0;
    rst_left   = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NCYC; c++) begin
      rst      = (rst_left > 0);
      if_req   = w_if_req;
      if_addr  = w_if_addr;
      dm_read  = w_rd;
      dm_write = w_wr;
      dm_addr  = w_dm_addr;
      dm_wdata = w_dm_wdata;
      if (m_busy) ack = (m_age == m_delay + 1);
      else        ack = stale_kick || ($urandom_range(0, 5) == 0);
      stale_kick = 0;
      mem_ack   = ack;
      mem_rdata = $urandom;
      #3;

      e_dm_pend = (w_rd || w_wr) && !m_dm_done;
      e_if_pend = w_if_req && !m_if_done;
      e_stall   = rst || e_dm_pend || e_if_pend;

      check_eq("stall_all",   32'(stall_all),   32'(e_stall));
      check_eq("mem_req",     32'(mem_req),     32'(m_busy));
      check_eq("mem_we",      32'(mem_we),      32'(m_we));
      check_eq("mem_addr",    mem_addr,         m_addr);
      check_eq("mem_wdata",   mem_wdata,        m_wdata);
      check_eq("if_valid",    32'(if_valid),    32'(m_if_done));
      check_eq("dm_valid",    32'(dm_valid),    32'(m_dm_done));
      check_eq("if_rdata",    if_rdata,         m_if_buf);
      check_eq("dm_rdata",    dm_rdata,         m_dm_buf);
      check_eq("stall_cnt",   stall_cnt,        m_stall_cnt);
      check_eq("err_timeout", 32'(err_timeout), 32'(m_err));

      if (rst) begin
        if (m_busy) stale_kick = 1;
        model_reset();
      end else begin
        m_stall_cnt = m_stall_cnt + 32'(e_stall);
        if (m_busy) begin
          // Before this cycle the access had already waited m_age-1 cycles.
          if (m_age - 1 >= TO) m_err = 1;
          if (ack) begin
            m_busy = 0;
            if (m_is_data) begin
              if (!m_we) m_dm_buf = mem_rdata;
              m_dm_done = 1;
            end else begin
              m_if_buf  = mem_rdata;
              m_if_done = 1;
            end
          end else begin
            m_age++;
          end
        end else if (e_dm_pend) begin
          start_access(1);
        end else if (e_if_pend) begin
          start_access(0);
        end
        if (!e_stall) begin
          m_dm_done = 0;
          m_if_done = 0;
        end
      end

      if (!e_stall) new_window();
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 199) == 0) rst_left = $urandom_range(1, 2);

      @(posedge clk);
      #1;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
